// File: rtl/dm_loader.sv
// Host-side loader/unloader for the 8-bit core's data memory.
// Fills dat_mem from a byte stream, runs the core until Done or timeout, then streams a memory window back out.
module dm_loader #(
  parameter int          D          = 8,
  parameter logic [15:0] MAX_CYCLES = 16'hFFFF
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [D:0]   LoadCount,
  input  logic [D-1:0] DumpBase,
  input  logic [D:0]   DumpCount,
  input  logic [7:0]   InData,
  input  logic         InValid,
  output logic         InReady,
  output logic         CpuReset,
  input  logic         CpuDone,
  output logic         MemSel,
  output logic [D-1:0] MemAddr,
  output logic         MemWriteEn,
  output logic [7:0]   MemDataIn,
  input  logic [7:0]   MemDataOut,
  output logic [7:0]   OutData,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [15:0]  RunCycles,
  output logic         Timeout,
  output logic         Finished
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DUMP, FINISH} state_t;

  localparam logic [15:0] RUN_LIMIT = MAX_CYCLES - 16'd1;

  state_t       state, next_state;
  logic [D-1:0] ptr;
  logic [D:0]   cnt;
  logic [D:0]   fetched;
  logic [D:0]   load_count;
  logic [D-1:0] dump_base;
  logic [D:0]   dump_count;
  logic [15:0]  run_cycles;
  logic         timeout;
  logic         out_valid;
  logic [7:0]   out_data;

  logic       start_ok;
  logic       load_beat;
  logic       load_last;
  logic       done_hit;
  logic       limit_hit;
  logic       out_beat;
  logic       dump_last;
  logic       fetch;
  logic [D:0] cnt_inc;

  assign cnt_inc   = cnt + 1'b1;
  assign start_ok  = Start && ((state == IDLE) || (state == FINISH));
  assign load_beat = (state == LOAD) && InValid;
  assign load_last = load_beat && (cnt_inc == load_count);
  // Done is ignored on the first RUN cycle, which is exactly when run_cycles is still 0.
  assign done_hit  = (state == RUN) && CpuDone && (run_cycles != 16'd0);
  assign limit_hit = (state == RUN) && !done_hit && (run_cycles == RUN_LIMIT);
  assign out_beat  = (state == DUMP) && out_valid && OutReady;
  assign dump_last = out_beat && (cnt_inc == dump_count);
  assign fetch     = (state == DUMP) && (!out_valid || OutReady) && (fetched != dump_count);

  always_ff @(posedge Clk) begin
    if (!Reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, FINISH: if (Start) next_state = (LoadCount != '0) ? LOAD : RUN;
      LOAD:         if (load_last) next_state = RUN;
      RUN: begin
        if (done_hit)       next_state = (dump_count != '0) ? DUMP : FINISH;
        else if (limit_hit) next_state = FINISH;
      end
      DUMP:         if (dump_last) next_state = FINISH;
      default:      next_state = IDLE;
    endcase
  end

  // Stream/write strobes are gated by Reset so nothing is written on an aborting edge.
  always_comb begin
    InReady    = 1'b0;
    CpuReset   = 1'b1;
    MemSel     = 1'b0;
    MemWriteEn = 1'b0;
    Finished   = 1'b0;
    case (state)
      LOAD: begin
        InReady    = Reset;
        MemSel     = 1'b1;
        MemWriteEn = InValid && Reset;
      end
      RUN:     CpuReset = 1'b0;
      DUMP:    MemSel   = 1'b1;
      FINISH:  Finished = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      ptr        <= '0;
      cnt        <= '0;
      fetched    <= '0;
      load_count <= '0;
      dump_base  <= '0;
      dump_count <= '0;
      run_cycles <= '0;
      timeout    <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      if (start_ok) begin
        load_count <= LoadCount;
        dump_base  <= DumpBase;
        dump_count <= DumpCount;
        ptr        <= '0;
        cnt        <= '0;
        fetched    <= '0;
        run_cycles <= '0;
        timeout    <= 1'b0;
      end
      if (load_beat) begin
        ptr <= ptr + 1'b1;
        cnt <= cnt_inc;
      end
      if (state == RUN) begin
        if (run_cycles != 16'hFFFF) run_cycles <= run_cycles + 16'd1;
        if (limit_hit) timeout <= 1'b1;
        if (done_hit) begin
          ptr     <= dump_base;
          cnt     <= '0;
          fetched <= '0;
        end
      end
      // Output register slice: refill whenever the held byte is empty or being taken.
      if (fetch) begin
        out_data  <= MemDataOut;
        out_valid <= 1'b1;
        ptr       <= ptr + 1'b1;
        fetched   <= fetched + 1'b1;
      end else if (out_beat) begin
        out_valid <= 1'b0;
      end
      if (out_beat) cnt <= cnt_inc;
    end
  end

  assign MemAddr   = ptr;
  assign MemDataIn = InData;
  assign OutData   = out_data;
  assign OutValid  = out_valid;
  assign RunCycles = run_cycles;
  assign Timeout   = timeout;

endmodule

// File: doc/dm_loader.md
Name: dm_loader

Overview:
- Host-side memory loader/unloader for the 8-bit core's data memory.
- Streams a program's input bytes into dat_mem while the core is held in reset, then releases the core.
- Waits for the core's Done, re-asserts core reset, then streams a selected window of data memory back out.
- Sits between an external byte stream and the dat_mem port; the top level muxes the dat_mem port between this block and the core on MemSel.

Parameters:
D, 8, data memory address width (depth 2^D)
MAX_CYCLES, 16'hFFFF, run-phase cycle limit before timeout

Ports:
Clk  in  1  clock
Reset  in  1  synchronous reset, active-low; block is in reset when Reset==0 at a rising Clk edge
Start  in  1  begin load/run/dump sequence; sampled in IDLE or FINISH only
LoadCount  in  D+1  bytes to load (0..2^D), latched on accepted Start
DumpBase  in  D  first dump address, latched on accepted Start
DumpCount  in  D+1  bytes to dump (0..2^D), latched on accepted Start
InData  in  8  load stream byte
InValid  in  1  load stream valid
InReady  out  1  load stream ready
CpuReset  out  1  active-high reset to core
CpuDone  in  1  core Done/halt flag
MemSel  out  1  1 = this block owns the dat_mem port
MemAddr  out  D  dat_mem address
MemWriteEn  out  1  dat_mem write enable
MemDataIn  out  8  dat_mem write data
MemDataOut  in  8  dat_mem read data (combinational read)
OutData  out  8  dump stream byte
OutValid  out  1  dump stream valid
OutReady  in  1  dump stream ready
RunCycles  out  16  cycles spent in RUN, saturating
Timeout  out  1  RUN ended by MAX_CYCLES
Finished  out  1  sequence complete

Behaviour:
- Reset (Reset==0 at edge): state=IDLE, pointers/counters=0, RunCycles=0, Timeout=0, OutValid=0, OutData=0.
- Reset values of combinational outputs: InReady=0, MemWriteEn=0, MemSel=0, Finished=0, CpuReset=1.
- Reset mid-operation aborts immediately with the same values; no partial stream handshake completes on that edge.
- States are IDLE, LOAD, RUN, DUMP, FINISH.
- IDLE:
  - CpuReset=1, MemSel=0.
  - Start=1 latches LoadCount/DumpBase/DumpCount and clears ptr, cnt, RunCycles and Timeout.
  - Next state is LOAD if LoadCount!=0, else RUN.
- LOAD:
  - CpuReset=1, MemSel=1, InReady=1.
  - MemWriteEn=InValid (combinational), MemAddr=ptr, MemDataIn=InData.
  - On each InValid&InReady edge: ptr++ and cnt++.
  - When cnt reaches LoadCount on the accepting edge: go to RUN, with InReady low from the next cycle.
  - Load addresses start at 0.
- RUN:
  - CpuReset=0, MemSel=0, MemWriteEn=0.
  - RunCycles increments each RUN cycle, saturating at 16'hFFFF.
  - CpuDone sampled high: go to DUMP if DumpCount!=0, else FINISH. CpuDone is ignored on the first RUN cycle (core still leaving reset).
  - RunCycles==MAX_CYCLES-1 without Done: set Timeout=1 and go to FINISH (no dump).
- DUMP:
  - CpuReset=1, MemSel=1, MemWriteEn=0, MemAddr=ptr.
  - ptr is loaded with DumpBase on DUMP entry; cnt is cleared.
  - Register-slice output: when OutValid==0 or OutReady==1, capture OutData<=MemDataOut, set OutValid=1, ptr++ (wraps mod 2^D).
  - OutData is held stable while OutValid&!OutReady.
  - cnt increments per accepted beat (OutValid&OutReady).
  - No fetch is issued once DumpCount fetches have been made.
  - After the last beat is accepted: OutValid=0, go to FINISH.
  - Throughput is 1 byte/cycle with OutReady held high; first OutValid appears 1 cycle after DUMP entry.
- FINISH:
  - Finished=1, CpuReset=1, MemSel=0; RunCycles and Timeout hold.
  - Start=1 relatches parameters and behaves as in IDLE.
- Start is ignored in LOAD/RUN/DUMP.
- LoadCount=2^D fills all of memory. DumpBase+DumpCount beyond 2^D wraps to address 0.

Test Plan:
- Reset low for 2 cycles mid-LOAD after 3 bytes -> IDLE, CpuReset=1, InReady=0, MemWriteEn=0; no 4th write.
- Start, LoadCount=4, bytes 11,22,33,44 with InValid gapped every other cycle -> writes addr0..3 = 11,22,33,44; MemWriteEn only on valid cycles; RUN entered after the 4th byte; CpuReset falls the next cycle.
- Memory model (addr 0x10..0x13 = A0..A3), CpuDone raised 20 RUN cycles in, DumpBase=0x10, DumpCount=4, OutReady constant 1 -> OutData A0,A1,A2,A3 on consecutive cycles; Finished=1 after; RunCycles=20.
- Same dump with OutReady toggling 1,0,0,1... -> OutData/OutValid held during stalls; no byte skipped or duplicated; exactly 4 beats accepted.
- DumpBase=0xFE, DumpCount=4 -> addresses FE,FF,00,01 read in order.
- LoadCount=0, DumpCount=0, MAX_CYCLES=50, CpuDone never high -> IDLE->RUN directly; Timeout=1 and FINISH after 50 RUN cycles; OutValid never asserted.
